// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generator controller.
// Holds the FSM state encoding, default sizing and the length clamp.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_REP_W   = 8;

  // Zero or oversize lengths both mean "use the full pattern register".
  function automatic int clamp_len(input int len, input int max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_bit_sel.sv
// Pattern holder and bit-index counter; next_bit is the bit due on the following cycle.
// Emission order: index 0 upward, or L-1 downward when SEQ_GEN_CTRL_MSB_FIRST_EN is defined.
module seq_bit_sel
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               adv,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  output logic               wrap,
  output logic               next_bit
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] pat_sel;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [LEN_W-1:0]   idx_d;
  logic [LEN_W-1:0]   pos;

  assign wrap = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    idx_d    = idx_q;
    pat_sel  = pattern_q;
    next_bit = 1'b0;
    if (load) begin
      idx_d   = '0;
      pat_sel = pattern_in;
    end else if (adv) begin
      idx_d = wrap ? '0 : idx_q + LEN_W'(1);
    end
`ifdef SEQ_GEN_CTRL_MSB_FIRST_EN
    pos = (load ? len_in : len_q) - LEN_W'(1) - idx_d;
`else
    pos = idx_d;
`endif
    for (int i = 0; i < MAX_LEN; i++) begin
      if (pos == LEN_W'(i)) next_bit = pat_sel[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      if (load) begin
        pattern_q <= pattern_in;
        len_q     <= len_in;
      end
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seq_gen_ctrl.sv
// Programmable serial pattern generator: L bits x R passes (R=0 runs until stop), one-cycle done.
// First bit one cycle after handshake; cfg_ready only in IDLE. SEQ_GEN_CTRL_MSB_FIRST_EN reverses order.
module seq_gen_ctrl
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int REP_W   = DEF_REP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [REP_W-1:0]   cfg_repeat,
  input  logic               stop,
  output logic               data,
  output logic               data_valid,
  output logic               busy,
  output logic               done
);

  state_t             state_q;
  state_t             state_d;
  logic               load;
  logic               adv;
  logic               wrap;
  logic               next_bit;
  logic               last_bit;
  logic [LEN_W-1:0]   len_eff;
  logic [REP_W-1:0]   rep_q;
  logic [REP_W-1:0]   pass_q;

  assign cfg_ready = (state_q == S_IDLE);
  assign len_eff   = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
  // R=0 never matches, so continuous runs only end through stop.
  assign last_bit  = wrap && (rep_q != '0) && (pass_q == rep_q - REP_W'(1));

  seq_bit_sel #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_bit_sel (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .adv        (adv),
    .pattern_in (cfg_pattern),
    .len_in     (len_eff),
    .wrap       (wrap),
    .next_bit   (next_bit)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop || last_bit) state_d = S_DONE;
        else                  adv     = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rep_q      <= '0;
      pass_q     <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_valid <= (state_d == S_RUN);
      data       <= (state_d == S_RUN) && next_bit;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      if (load) begin
        rep_q  <= cfg_repeat;
        pass_q <= '0;
      end else if (adv && wrap && (rep_q != '0)) begin
        pass_q <= pass_q + REP_W'(1);
      end
    end
  end

endmodule
